// File: rtl/tdm_mux2_defs.sv
// Shared encodings for the TDM 2:1 mux sequencer.
// State codes, select values and gate polarity.
package tdm_mux2_defs;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BLANK_A = 3'd1,
    DRIVE_A = 3'd2,
    BLANK_B = 3'd3,
    DRIVE_B = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic SEL_A    = 1'b0;
  localparam logic SEL_B    = 1'b1;
  localparam logic GATE_OFF = 1'b1;
  localparam logic GATE_ON  = 1'b0;

endpackage

// File: rtl/tdm_dwell_cnt.sv
// Loadable dwell down-counter with zero flag.
// Load wins over decrement.
module tdm_dwell_cnt #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               dec,
  input  logic [DWELL_W-1:0] load_val,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - {{(DWELL_W-1){1'b0}}, 1'b1};
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/tdm_mux2_ctrl.sv
// Break-before-make TDM sequencer for the gated 2:1 mux.
// Define TDM_MUX2_CAPTURE_EN to add y sampling (y_a / y_b).
module tdm_mux2_ctrl
  import tdm_mux2_defs::*;
#(
  parameter int DWELL_W  = 4,
  parameter int FRAMES_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic [DWELL_W-1:0]  dwell_a,
  input  logic [DWELL_W-1:0]  dwell_b,
  input  logic [FRAMES_W-1:0] frames,
  output logic                sel,
  output logic                gbar,
  output logic                busy,
  output logic                done,
  output logic [FRAMES_W-1:0] frame_cnt
`ifdef TDM_MUX2_CAPTURE_EN
  ,
  input  logic                y,
  output logic                y_a,
  output logic                y_b
`endif
);

  localparam logic [FRAMES_W-1:0] FC_ONE = 1;

  state_t              state, state_n;
  logic [DWELL_W-1:0]  da_q, db_q;
  logic [FRAMES_W-1:0] fr_q;

  logic                sel_n, gbar_n;
  logic                busy_n, done_n;
  logic [FRAMES_W-1:0] fc_n, fc_inc;
  logic                latch;
  logic                cnt_load, cnt_dec;
  logic [DWELL_W-1:0]  cnt_val;
  logic                cnt_zero;

  tdm_dwell_cnt #(
    .DWELL_W (DWELL_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  assign fc_inc = frame_cnt + FC_ONE;

  always_comb begin
    state_n  = state;
    sel_n    = sel;
    gbar_n   = GATE_OFF;
    busy_n   = 1'b1;
    done_n   = 1'b0;
    fc_n     = frame_cnt;
    latch    = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = da_q;
    unique case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          state_n = BLANK_A;
          sel_n   = SEL_A;
          busy_n  = 1'b1;
          fc_n    = '0;
          latch   = 1'b1;
        end
      end
      BLANK_A: begin
        state_n  = DRIVE_A;
        gbar_n   = GATE_ON;
        cnt_load = 1'b1;
        cnt_val  = da_q;
      end
      DRIVE_A: begin
        if (cnt_zero) begin
          state_n = BLANK_B;
          sel_n   = SEL_B;
        end else begin
          gbar_n  = GATE_ON;
          cnt_dec = 1'b1;
        end
      end
      BLANK_B: begin
        state_n  = DRIVE_B;
        gbar_n   = GATE_ON;
        cnt_load = 1'b1;
        cnt_val  = db_q;
      end
      DRIVE_B: begin
        if (cnt_zero) begin
          fc_n = fc_inc;
          if (fr_q != '0 && fc_inc == fr_q) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = BLANK_A;
            sel_n   = SEL_A;
          end
        end else begin
          gbar_n  = GATE_ON;
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
    // stop overrides everything, including the frame count update
    if (stop && state != IDLE) begin
      state_n  = IDLE;
      sel_n    = sel;
      gbar_n   = GATE_OFF;
      busy_n   = 1'b0;
      done_n   = 1'b0;
      fc_n     = frame_cnt;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= SEL_A;
      gbar      <= GATE_OFF;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
      da_q      <= '0;
      db_q      <= '0;
      fr_q      <= '0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      gbar      <= gbar_n;
      busy      <= busy_n;
      done      <= done_n;
      frame_cnt <= fc_n;
      if (latch) begin
        da_q <= dwell_a;
        db_q <= dwell_b;
        fr_q <= frames;
      end
    end
  end

`ifdef TDM_MUX2_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_a <= 1'b0;
      y_b <= 1'b0;
    end else begin
      if (state == DRIVE_A && cnt_zero) y_a <= y;
      if (state == DRIVE_B && cnt_zero) y_b <= y;
    end
  end
`endif

endmodule

// File: tb/tb_tdm_mux2_ctrl.sv
// Randomized bench for tdm_mux2_ctrl against a schedule-queue model.
// Honours TDM_MUX2_CAPTURE_EN when defined.
module tb_tdm_mux2_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] dwell_a = '0;
  logic [3:0] dwell_b = '0;
  logic [7:0] frames = '0;
  logic       sel, gbar, busy, done;
  logic [7:0] frame_cnt;
`ifdef TDM_MUX2_CAPTURE_EN
  logic       y_pat = 1'b0;
  logic       y, y_a, y_b;
  assign y = y_pat ^ sel;
`endif

  always #5 clk = ~clk;

  tdm_mux2_ctrl #(
    .DWELL_W  (4),
    .FRAMES_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .dwell_a   (dwell_a),
    .dwell_b   (dwell_b),
    .frames    (frames),
    .sel       (sel),
    .gbar      (gbar),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt)
`ifdef TDM_MUX2_CAPTURE_EN
    ,
    .y         (y),
    .y_a       (y_a),
    .y_b       (y_b)
`endif
  );

  typedef struct packed {
    logic       sel;
    logic       gbar;
    logic       busy;
    logic       done;
    logic [7:0] fc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic sel_last = 1'b0;
  logic sel_prev = 1'b0;
  logic [7:0] fc_last = '0;
  logic busy_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, got, exp);
    end
  endtask

  // Cycle-by-cycle expectation for one run, from the frame layout
  task automatic push_run(input int da, input int db, input int fr,
                          input int ncont);
    int n;
    exp_t e;
    n = (fr != 0) ? fr : ncont;
    for (int f = 0; f < n; f++) begin
      e = '{sel: 1'b0, gbar: 1'b1, busy: 1'b1, done: 1'b0, fc: 8'(f)};
      q.push_back(e);
      e.gbar = 1'b0;
      for (int k = 0; k <= da; k++) q.push_back(e);
      e.sel = 1'b1;
      e.gbar = 1'b1;
      q.push_back(e);
      e.gbar = 1'b0;
      for (int k = 0; k <= db; k++) q.push_back(e);
    end
    if (fr != 0) begin
      e = '{sel: 1'b1, gbar: 1'b1, busy: 1'b1, done: 1'b1, fc: 8'(fr)};
      q.push_back(e);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) e = q.pop_front();
    else e = '{sel: sel_last, gbar: 1'b1, busy: 1'b0, done: 1'b0,
               fc: fc_last};
    chk("sel", 32'(sel), 32'(e.sel));
    chk("gbar", 32'(gbar), 32'(e.gbar));
    chk("busy", 32'(busy), 32'(e.busy));
    chk("done", 32'(done), 32'(e.done));
    chk("frame_cnt", 32'(frame_cnt), 32'(e.fc));
    chk("glitch", 32'(~gbar & (sel ^ sel_prev)), 32'd0);
    sel_prev  = sel;
    sel_last  = e.sel;
    fc_last   = e.fc;
    busy_last = e.busy;
  endtask

  task automatic launch(input int da, input int db, input int fr,
                        input int ncont, input bit with_stop);
    dwell_a = 4'(da);
    dwell_b = 4'(db);
    frames  = 8'(fr);
    start   = 1'b1;
    stop    = with_stop;
    if (!busy_last) push_run(da, db, fr, ncont);
    step();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Mid-run noise: shuffled config inputs and ignored start pulses
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      dwell_a = 4'($urandom);
      dwell_b = 4'($urandom);
      frames  = 8'($urandom);
      start   = (q.size() > 0) && ($urandom_range(0, 5) == 0);
      step();
      start = 1'b0;
    end
  endtask

  task automatic run_out();
    int guard = 0;
    while (q.size() > 0 && guard < 5000) begin
      steps(1);
      guard++;
    end
    chk("run_bound", 32'(q.size()), 32'd0);
    steps(2);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    q.delete();
    step();
    stop = 1'b0;
  endtask

  initial begin
    int da, db;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (4) step();

    // directed finite run
    launch(2, 0, 2, 0, 1'b0);
    run_out();

    // glitch-free soak with random dwells
    launch(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           50, 0, 1'b0);
    run_out();

    for (int r = 0; r < 4; r++) begin
      launch(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(1, 4)), 0, r[0]);
      run_out();
    end

    // stop in first DRIVE_B cycle of frame 2
    da = 1;
    db = 3;
    launch(da, db, 5, 0, 1'b0);
    steps(2 * (da + db + 4) + da + 3);
    chk("pre_stop_fc", 32'(frame_cnt), 32'd2);
    do_stop();
    steps(3);
    launch(0, 2, 1, 0, 1'b0);
    run_out();

    // stop on the final DRIVE_B cycle suppresses done
    launch(0, 0, 1, 0, 1'b0);
    steps(3);
    do_stop();
    steps(3);

    // continuous mode across the frame counter wrap
    launch(0, 0, 0, 270, 1'b0);
    steps(260 * 4);
    chk("wrap_fc", 32'(frame_cnt), 32'd4);
    do_stop();
    steps(3);

    // reset in the middle of a run
    launch(3, 3, 3, 0, 1'b0);
    steps(7);
    rst_n = 1'b0;
    q.delete();
    sel_last = 1'b0;
    fc_last  = '0;
    step();
    rst_n = 1'b1;
    steps(3);

`ifdef TDM_MUX2_CAPTURE_EN
    y_pat = 1'b1;
    launch(1, 2, 1, 0, 1'b0);
    run_out();
    chk("y_a", 32'(y_a), 32'd1);
    chk("y_b", 32'(y_b), 32'd0);
    y_pat = 1'b0;
    launch(2, 1, 1, 0, 1'b0);
    run_out();
    chk("y_a_swap", 32'(y_a), 32'd0);
    chk("y_b_swap", 32'(y_b), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
